// File: rtl/pll_rst_seq.sv
// PLL lock supervisor: waits for lock to be stable, then releases the reset tree
// one stage at a time. A loss of lock re-asserts every stage and is counted.
module pll_rst_seq #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int N_STAGES      = 3,
    parameter int STAGE_GAP     = 16,
    parameter int SOFT_HOLD     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                lock,
    input  logic                soft_rst,
    input  logic                clr_lost,
    output logic [N_STAGES-1:0] rst_out_n,
    output logic                ready,
    output logic                lock_lost,
    output logic [7:0]          relock_cnt
);

    localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int HW = (SOFT_HOLD > 1) ? $clog2(SOFT_HOLD) : 1;
    localparam int IW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(SOFT_HOLD - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_STAGES - 1);

    localparam logic [2:0] WAIT_LOCK = 3'd0;
    localparam logic [2:0] STABLE    = 3'd1;
    localparam logic [2:0] RELEASE   = 3'd2;
    localparam logic [2:0] RUN       = 3'd3;
    localparam logic [2:0] SOFT      = 3'd4;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic [2:0]             state;
    logic [SW-1:0]          stab_cnt;
    logic [GW-1:0]          gap_cnt;
    logic [HW-1:0]          soft_cnt;
    logic [IW-1:0]          idx;
    logic [N_STAGES-1:0]    stage_bit;
    logic                   loss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], lock};
    end

    assign lock_s    = sync_q[SYNC_STAGES-1];
    assign stage_bit = N_STAGES'(1) << idx;
    // A drop while still qualifying (STABLE) is a glitch, not a loss event.
    assign loss      = !lock_s && (state == RELEASE || state == RUN || state == SOFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_LOCK;
            stab_cnt  <= '0;
            gap_cnt   <= '0;
            soft_cnt  <= '0;
            idx       <= '0;
            rst_out_n <= '0;
            ready     <= 1'b0;
        end else if (loss) begin
            state     <= WAIT_LOCK;
            rst_out_n <= '0;
            ready     <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    rst_out_n <= '0;
                    ready     <= 1'b0;
                    if (lock_s) begin
                        state    <= STABLE;
                        stab_cnt <= '0;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state    <= WAIT_LOCK;
                        stab_cnt <= '0;
                    end else if (stab_cnt == STAB_LAST) begin
                        state   <= RELEASE;
                        gap_cnt <= '0;
                        idx     <= '0;
                    end else begin
                        stab_cnt <= stab_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt   <= '0;
                        rst_out_n <= rst_out_n | stage_bit;
                        idx       <= idx + 1'b1;
                        if (idx == IDX_LAST) begin
                            state <= RUN;
                            ready <= 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (soft_rst) begin
                        state     <= SOFT;
                        rst_out_n <= '0;
                        ready     <= 1'b0;
                        soft_cnt  <= '0;
                    end
                end
                SOFT: begin
                    // Lock is known good here, so go straight back to staged release.
                    if (soft_cnt == HOLD_LAST) begin
                        state   <= RELEASE;
                        gap_cnt <= '0;
                        idx     <= '0;
                    end else begin
                        soft_cnt <= soft_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= WAIT_LOCK;
                    rst_out_n <= '0;
                    ready     <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_lost  <= 1'b0;
            relock_cnt <= '0;
        end else begin
            if (loss)          lock_lost <= 1'b1;
            else if (clr_lost) lock_lost <= 1'b0;
            if (loss && relock_cnt != 8'hFF) relock_cnt <= relock_cnt + 1'b1;
        end
    end

endmodule
